// File: rtl/calc1_req_driver_if.sv
// Host-side and calc1-port-side signal bundle for calc1_req_driver.
// The master modport is the driver itself; the slave modport is whoever
// plays host and calc1 port (the bench, or the surrounding logic).
interface calc1_req_driver_if;
    logic        host_valid;
    logic        host_ready;
    logic [3:0]  host_cmd;
    logic [31:0] host_op1;
    logic [31:0] host_op2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        spurious_err;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  out_resp;
    logic [31:0] out_data;

    modport master (
        input  host_valid, host_cmd, host_op1, host_op2, rsp_ready, out_resp, out_data,
        output host_ready, rsp_valid, rsp_resp, rsp_data, rsp_timeout, spurious_err,
               req_cmd_out, req_data_out
    );

    modport slave (
        output host_valid, host_cmd, host_op1, host_op2, rsp_ready, out_resp, out_data,
        input  host_ready, rsp_valid, rsp_resp, rsp_data, rsp_timeout, spurious_err,
               req_cmd_out, req_data_out
    );
endinterface

// File: rtl/calc1_req_driver.sv
// calc1_req_driver: takes one complete calc1 operation from a host, plays the
// two-cycle request sequence onto a calc1 port, waits (bounded) for the
// response and hands the result back. Every output comes straight from a flop.
module calc1_req_driver #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               c_clk,
    input  logic               reset_n,
    calc1_req_driver_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_SEND1, S_SEND2, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_state_next;
    logic [7:0]  r_cnt, w_cnt_next;
    logic [31:0] r_op2, w_op2_next;
    logic        r_host_ready, w_host_ready_next;
    logic        r_rsp_valid, w_rsp_valid_next;
    logic [1:0]  r_rsp_resp, w_rsp_resp_next;
    logic [31:0] r_rsp_data, w_rsp_data_next;
    logic        r_rsp_timeout, w_rsp_timeout_next;
    logic        r_spurious, w_spurious_next;
    logic [3:0]  r_req_cmd, w_req_cmd_next;
    logic [31:0] r_req_data, w_req_data_next;
    logic        w_resp_seen;

    assign w_resp_seen = (bus.out_resp != 2'd0);

    // Next state and next value of every output register. Port lines default
    // to 0 so calc1 only ever sees NOPs outside the two send cycles.
    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_op2_next         = r_op2;
        w_rsp_valid_next   = r_rsp_valid;
        w_rsp_resp_next    = r_rsp_resp;
        w_rsp_data_next    = r_rsp_data;
        w_rsp_timeout_next = r_rsp_timeout;
        w_req_cmd_next     = 4'd0;
        w_req_data_next    = 32'd0;
        w_spurious_next    = r_spurious | (w_resp_seen && (r_state != S_WAIT));
        case (r_state)
            S_IDLE: begin
                if (bus.host_valid && r_host_ready) begin
                    w_op2_next = bus.host_op2;
                    if (bus.host_cmd != 4'd0) begin
                        w_state_next    = S_SEND1;
                        w_req_cmd_next  = bus.host_cmd;
                        w_req_data_next = bus.host_op1;
                    end else begin
                        // cmd 0 is rejected locally; rsp_valid follows one edge later
                        w_state_next       = S_DONE;
                        w_rsp_valid_next   = 1'b0;
                        w_rsp_resp_next    = 2'd2;
                        w_rsp_data_next    = 32'd0;
                        w_rsp_timeout_next = 1'b0;
                    end
                end
            end
            S_SEND1: begin
                w_state_next    = S_SEND2;
                w_req_data_next = r_op2;
            end
            S_SEND2: begin
                w_state_next = S_WAIT;
                w_cnt_next   = 8'd0;
            end
            S_WAIT: begin
                w_cnt_next = r_cnt + 8'd1;
                // a response on the timeout edge still wins
                if (w_resp_seen) begin
                    w_state_next       = S_DONE;
                    w_rsp_valid_next   = 1'b1;
                    w_rsp_resp_next    = bus.out_resp;
                    w_rsp_data_next    = bus.out_data;
                    w_rsp_timeout_next = 1'b0;
                end else if (r_cnt == LP_LAST) begin
                    w_state_next       = S_DONE;
                    w_rsp_valid_next   = 1'b1;
                    w_rsp_resp_next    = 2'd3;
                    w_rsp_data_next    = 32'd0;
                    w_rsp_timeout_next = 1'b1;
                end
            end
            S_DONE: begin
                // rsp_ready only counts once the result is actually offered
                if (!r_rsp_valid) begin
                    w_rsp_valid_next = 1'b1;
                end else if (bus.rsp_ready) begin
                    w_state_next       = S_IDLE;
                    w_rsp_valid_next   = 1'b0;
                    w_rsp_resp_next    = 2'd0;
                    w_rsp_data_next    = 32'd0;
                    w_rsp_timeout_next = 1'b0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        w_host_ready_next = (w_state_next == S_IDLE);
    end

    // State register.
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Output, operand and wait-counter registers; reset clears everything at once.
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt         <= 8'd0;
            r_op2         <= 32'd0;
            r_host_ready  <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_resp    <= 2'd0;
            r_rsp_data    <= 32'd0;
            r_rsp_timeout <= 1'b0;
            r_spurious    <= 1'b0;
            r_req_cmd     <= 4'd0;
            r_req_data    <= 32'd0;
        end else begin
            r_cnt         <= w_cnt_next;
            r_op2         <= w_op2_next;
            r_host_ready  <= w_host_ready_next;
            r_rsp_valid   <= w_rsp_valid_next;
            r_rsp_resp    <= w_rsp_resp_next;
            r_rsp_data    <= w_rsp_data_next;
            r_rsp_timeout <= w_rsp_timeout_next;
            r_spurious    <= w_spurious_next;
            r_req_cmd     <= w_req_cmd_next;
            r_req_data    <= w_req_data_next;
        end
    end

    assign bus.host_ready   = r_host_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_resp     = r_rsp_resp;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_timeout  = r_rsp_timeout;
    assign bus.spurious_err = r_spurious;
    assign bus.req_cmd_out  = r_req_cmd;
    assign bus.req_data_out = r_req_data;
endmodule

// File: tb/tb_calc1_req_driver.sv
// Bench for calc1_req_driver: directed cases plus randomized operations, each
// checked against a cycle-level expectation derived from the operation
// (send trace, response edge, result fields, spurious flag).
module tb_calc1_req_driver;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   exp_spur = 1'b0;

    calc1_req_driver_if bus_if ();

    calc1_req_driver #(.TIMEOUT(TIMEOUT)) dut (
        .c_clk   (clk),
        .reset_n (rst_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // wait (bounded) for host_ready, then complete the handshake at edge E0
    task automatic issue(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                         output bit ok);
        int w;
        w  = 0;
        ok = 1'b0;
        while (bus_if.host_ready !== 1'b1 && w < 10) begin
            step();
            w++;
        end
        check("host_ready_idle", 64'(bus_if.host_ready), 64'd1);
        if (bus_if.host_ready !== 1'b1) return;
        bus_if.host_valid = 1'b1;
        bus_if.host_cmd   = cmd;
        bus_if.host_op1   = op1;
        bus_if.host_op2   = op2;
        step();
        bus_if.host_valid = 1'b0;
        bus_if.host_cmd   = 4'($urandom);
        bus_if.host_op1   = $urandom;
        bus_if.host_op2   = $urandom;
        check("host_ready_busy", 64'(bus_if.host_ready), 64'd0);
        ok = 1'b1;
    endtask

    // One full operation. silent: responder never answers; otherwise it answers
    // with (r, x) sampled d edges after WAIT entry. spur drives resp=1 in SEND1.
    task automatic run_op(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                          input bit silent, input int d, input logic [1:0] r, input logic [31:0] x,
                          input bit spur, input int bp, input bit early);
        bit          ok;
        int          kexp;
        logic [1:0]  e_resp;
        logic [31:0] e_data;
        logic        e_to;
        bus_if.rsp_ready = early;
        issue(cmd, op1, op2, ok);
        if (!ok) return;
        if (cmd == 4'd0) begin
            e_resp = 2'd2; e_data = 32'd0; e_to = 1'b0;
            check("nop_port_e0", {bus_if.req_cmd_out, bus_if.req_data_out}, 64'd0);
            check("nop_valid_e0", 64'(bus_if.rsp_valid), 64'd0);
            step();
            check("nop_port_e1", {bus_if.req_cmd_out, bus_if.req_data_out}, 64'd0);
        end else begin
            kexp   = silent ? TIMEOUT : d;
            e_resp = silent ? 2'd3 : r;
            e_data = silent ? 32'd0 : x;
            e_to   = silent;
            check("send1_cmd", 64'(bus_if.req_cmd_out), 64'(cmd));
            check("send1_data", 64'(bus_if.req_data_out), 64'(op1));
            if (spur) begin
                bus_if.out_resp = 2'd1;
                exp_spur = 1'b1;
            end
            step();
            bus_if.out_resp = 2'd0;
            check("send2_cmd", 64'(bus_if.req_cmd_out), 64'd0);
            check("send2_data", 64'(bus_if.req_data_out), 64'(op2));
            step();
            check("wait_entry_port", {bus_if.req_cmd_out, bus_if.req_data_out}, 64'd0);
            for (int k = 1; k <= kexp; k++) begin
                if (!silent && k == d) begin
                    bus_if.out_resp = r;
                    bus_if.out_data = x;
                end
                step();
                bus_if.out_resp = 2'd0;
                bus_if.out_data = $urandom;
                if (k < kexp) begin
                    check("wait_valid", 64'(bus_if.rsp_valid), 64'd0);
                    check("wait_port", {bus_if.req_cmd_out, bus_if.req_data_out}, 64'd0);
                end
            end
        end
        check("rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
        check("rsp_resp", 64'(bus_if.rsp_resp), 64'(e_resp));
        check("rsp_data", 64'(bus_if.rsp_data), 64'(e_data));
        check("rsp_timeout", 64'(bus_if.rsp_timeout), 64'(e_to));
        check("spurious_err", 64'(bus_if.spurious_err), 64'(exp_spur));
        for (int c = 0; c < bp; c++) begin
            step();
            check("bp_valid", 64'(bus_if.rsp_valid), 64'd1);
            check("bp_resp_data", {30'd0, bus_if.rsp_resp, bus_if.rsp_data}, {30'd0, e_resp, e_data});
            check("bp_host_ready", 64'(bus_if.host_ready), 64'd0);
        end
        bus_if.rsp_ready = 1'b1;
        step();
        bus_if.rsp_ready = 1'b0;
        check("accept_host_ready", 64'(bus_if.host_ready), 64'd1);
        check("accept_valid", 64'(bus_if.rsp_valid), 64'd0);
        $display("op cmd=%0d op1=%08h op2=%08h -> resp=%0d data=%08h timeout=%0d",
                 cmd, op1, op2, e_resp, e_data, e_to);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {bus_if.host_ready, bus_if.rsp_valid, bus_if.rsp_resp, bus_if.rsp_timeout,
                    bus_if.spurious_err, bus_if.req_cmd_out}, 64'd0);
        check(tag, {bus_if.rsp_data, bus_if.req_data_out}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bus_if.host_valid = 1'b0;
        bus_if.host_cmd   = 4'd0;
        bus_if.host_op1   = 32'd0;
        bus_if.host_op2   = 32'd0;
        bus_if.rsp_ready  = 1'b0;
        bus_if.out_resp   = 2'd0;
        bus_if.out_data   = 32'd0;

        #2;
        check_all_zero("reset_outputs");
        #10;
        rst_n = 1'b1;
        check("host_ready_before_edge", 64'(bus_if.host_ready), 64'd0);
        step();
        check("host_ready_after_edge", 64'(bus_if.host_ready), 64'd1);

        // directed cases
        run_op(4'd1, 32'h0000_0001, 32'h01FF_FFFF, 1'b0, 3, 2'd1, 32'h0200_0000, 1'b0, 0, 1'b0);
        run_op(4'd2, $urandom, $urandom, 1'b1, 0, 2'd0, 32'd0, 1'b0, 0, 1'b0);
        run_op(4'd0, $urandom, $urandom, 1'b0, 0, 2'd0, 32'd0, 1'b0, 0, 1'b0);
        run_op(4'd0, $urandom, $urandom, 1'b0, 0, 2'd0, 32'd0, 1'b0, 0, 1'b1);
        run_op(4'd5, $urandom, $urandom, 1'b0, TIMEOUT, 2'd1, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
        run_op(4'd6, $urandom, $urandom, 1'b0, 1, 2'd1, 32'h8000_0001, 1'b0, 0, 1'b1);
        run_op(4'd1, 32'h7FFF_FFFF, 32'd1, 1'b0, 4, 2'd2, 32'h1234_5678, 1'b1, 0, 1'b0);
        run_op(4'd2, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 2, 2'd1, 32'h4B4B_4B4B, 1'b0, 5, 1'b0);

        // randomized operations
        for (int i = 0; i < 24; i++) begin
            logic [3:0] cmd;
            bit         sil;
            int         d;
            int         bp;
            bit         early;
            cmd   = 4'($urandom_range(0, 15));
            sil   = ($urandom_range(0, 7) == 0);
            d     = ($urandom_range(0, 5) == 0) ? TIMEOUT : $urandom_range(1, 8);
            bp    = $urandom_range(0, 3);
            early = (bp == 0) && ($urandom_range(0, 1) == 1);
            run_op(cmd, $urandom, $urandom, sil, d, 2'($urandom_range(1, 2)), $urandom,
                   1'b0, bp, early);
        end

        // reset in the middle of WAIT
        issue(4'd2, 32'd9, 32'd7, ok);
        if (ok) begin
            step();
            step();
            step();
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        exp_spur = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("held_reset_outputs");
        rst_n = 1'b1;
        run_op(4'd1, 32'd0, 32'd0, 1'b0, 3, 2'd1, 32'd0, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
